// File: rtl/mux_scan_ctrl.sv
// Scans an external 8-to-1 mux channel by channel and assembles the samples into one 8-bit word.
// Optional parity output is built only when SCAN_PARITY_EN is defined.
module mux_scan_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       mux_f,
  output logic [2:0] sel,
  output logic       busy,
  output logic       word_valid,
  input  logic       word_ready,
`ifdef SCAN_PARITY_EN
  output logic       parity,
`endif
  output logic [7:0] word
);

  localparam logic [3:0] CntLoad = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StSettle, StSample, StValid} state_e;

  state_e     state_q;
  logic [3:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      sel        <= 3'd0;
      word       <= 8'h00;
      busy       <= 1'b0;
      word_valid <= 1'b0;
`ifdef SCAN_PARITY_EN
      parity     <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            sel     <= 3'd0;
            word    <= 8'h00;
            cnt_q   <= CntLoad;
            busy    <= 1'b1;
            state_q <= StSettle;
`ifdef SCAN_PARITY_EN
            parity  <= 1'b0;
`endif
          end
        end
        StSettle: begin
          if (cnt_q == 4'd0) begin
            state_q <= StSample;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StSample: begin
          word[sel] <= mux_f;
          if (sel != 3'd7) begin
            sel     <= sel + 3'd1;
            cnt_q   <= CntLoad;
            state_q <= StSettle;
          end else begin
            state_q    <= StValid;
            word_valid <= 1'b1;
`ifdef SCAN_PARITY_EN
            // word[7] is still zero here; the bit arriving this edge is mux_f.
            parity     <= ^{mux_f, word[6:0]};
`endif
          end
        end
        StValid: begin
          if (word_ready) begin
            state_q    <= StIdle;
            word_valid <= 1'b0;
            busy       <= 1'b0;
            sel        <= 3'd0;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: two instances (settle 2 and settle 1) each driving a modelled 8-to-1 mux.
module tb_mux_scan_ctrl;

  localparam int S0 = 2;
  localparam int S1 = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start0, ready0, start1, ready1;
  logic [7:0] a0, a1;
  logic [2:0] sel0, sel1;
  logic       busy0, busy1, wv0, wv1;
  logic [7:0] word0, word1;
  logic       mux_f0, mux_f1;
`ifdef SCAN_PARITY_EN
  logic       par0, par1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Behavioural mux: F is input A[sel].
  assign mux_f0 = a0[sel0];
  assign mux_f1 = a1[sel1];

  mux_scan_ctrl #(.SETTLE_CYCLES(S0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .mux_f(mux_f0), .sel(sel0), .busy(busy0),
    .word_valid(wv0), .word_ready(ready0),
`ifdef SCAN_PARITY_EN
    .parity(par0),
`endif
    .word(word0)
  );

  mux_scan_ctrl #(.SETTLE_CYCLES(S1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .mux_f(mux_f1), .sel(sel1), .busy(busy1),
    .word_valid(wv1), .word_ready(ready1),
`ifdef SCAN_PARITY_EN
    .parity(par1),
`endif
    .word(word1)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full scan on dut0; optionally pokes start while busy and on the handshake edge.
  task automatic scan0(input logic [7:0] a, input int delay, input bit poke);
    int n;
    n = 8 * (S0 + 1);
    a0 = a;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    chk("busy_after_start", 8'(busy0), 8'd1);
    chk("sel_after_start", 8'(sel0), 8'd0);
    chk("word_cleared", word0, 8'h00);
    for (int k = 1; k <= n; k++) begin
      start0 = poke ? 1'($urandom) : 1'b0;
      ready0 = 1'($urandom);
      step();
      chk("sel_seq", 8'(sel0), (k < n) ? 8'(k / (S0 + 1)) : 8'd7);
      chk("wv_timing", 8'(wv0), (k == n) ? 8'd1 : 8'd0);
      chk("busy_scan", 8'(busy0), 8'd1);
    end
    start0 = 1'b0;
    ready0 = 1'b0;
    chk("word_value", word0, a);
`ifdef SCAN_PARITY_EN
    chk("parity", 8'(par0), 8'(^a));
`endif
    for (int d = 0; d < delay; d++) begin
      a0 = 8'($urandom);
      start0 = poke;
      step();
      chk("wv_hold", 8'(wv0), 8'd1);
      chk("word_hold", word0, a);
      chk("sel_hold", 8'(sel0), 8'd7);
    end
    ready0 = 1'b1;
    start0 = poke;
    step();
    ready0 = 1'b0;
    start0 = 1'b0;
    chk("wv_drop", 8'(wv0), 8'd0);
    chk("busy_drop", 8'(busy0), 8'd0);
    chk("sel_return", 8'(sel0), 8'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start0 = 1'b0; ready0 = 1'b0; start1 = 1'b0; ready1 = 1'b0;
    a0 = 8'h00; a1 = 8'h00;
    #1;
    chk("rst_sel", 8'(sel0), 8'd0);
    chk("rst_busy", 8'(busy0), 8'd0);
    chk("rst_wv", 8'(wv0), 8'd0);
    chk("rst_word", word0, 8'h00);
    step();
    step();
    rst_n = 1'b1;

    // Start right after reset release, then directed patterns.
    scan0(8'h04, 0, 1'b0);
    scan0(8'hA5, 10, 1'b0);
    scan0(8'h07, 2, 1'b1);
    // Start on the first IDLE cycle after a poked handshake is accepted.
    scan0(8'h3C, 0, 1'b1);

    // Reset mid-scan while sel=4 aborts with no word_valid.
    a0 = 8'hFF;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    for (int k = 1; k <= 4 * (S0 + 1); k++) step();
    chk("pre_rst_sel", 8'(sel0), 8'd4);
    rst_n = 1'b0;
    #1;
    chk("abort_sel", 8'(sel0), 8'd0);
    chk("abort_busy", 8'(busy0), 8'd0);
    chk("abort_word", word0, 8'h00);
    chk("abort_wv", 8'(wv0), 8'd0);
    step();
    rst_n = 1'b1;
    ready0 = 1'b1;
    for (int k = 0; k < 30; k++) begin
      step();
      chk("no_wv_after_abort", 8'(wv0), 8'd0);
    end
    ready0 = 1'b0;
    scan0(8'h5A, 1, 1'b0);

    // Settle of one cycle: each channel two cycles, word_valid at edge 16.
    a1 = 8'hFF;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    for (int k = 1; k <= 8 * (S1 + 1); k++) begin
      step();
      chk("s1_sel_seq", 8'(sel1), (k < 16) ? 8'(k / (S1 + 1)) : 8'd7);
      chk("s1_wv_timing", 8'(wv1), (k == 16) ? 8'd1 : 8'd0);
    end
    chk("s1_word", word1, 8'hFF);
    ready1 = 1'b1;
    step();
    ready1 = 1'b0;
    chk("s1_wv_drop", 8'(wv1), 8'd0);

    for (int r = 0; r < 6; r++) begin
      scan0(8'($urandom), int'($urandom_range(0, 5)), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
